tick_bcd_timer: RTL
===================

Name: tick_bcd_timer

Overview:
- Downstream consumer of the slow clock produced by the clock divider stage.
- Takes that divided clock as a plain data input and synchronises it into the fast system clock domain. Detects its rising edges and advances a 4-digit BCD MM:SS timer from 00:00 to 59:59.
- Supports up/down counting, synchronous clear, parallel BCD load with validity check, and a one-cycle wrap pulse.
- The BCD outputs feed the display stage.

Parameters:
- SYNC_STAGES, 2, flip-flops in the tick_in synchroniser before the edge-detect register. Legal range 2..4.
- MAX_MIN_TENS, 5, maximum value of the minutes-tens digit. The wrap point is MAX_MIN_TENS9:59.

Ports:
- I_CLK  in  1  system clock, rising-edge active.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- tick_in  in  1  divided clock from the divider stage, asynchronous to I_CLK for this block's purposes.
- en  in  1  count enable. While 0, detected edges are discarded, not queued.
- up  in  1  direction: 1 = count up, 0 = count down.
- clr  in  1  synchronous clear to 00:00.
- load  in  1  synchronous load of load_val.
- load_val  in  16  BCD {min_tens, min_units, sec_tens, sec_units}, 4 bits each.
- digits  out  16  current BCD value, same packing as load_val.
- wrap  out  1  one-cycle pulse on terminal-count rollover.
- load_err  out  1  one-cycle pulse when a load is rejected.
- tick_seen  out  1  one-cycle pulse on every detected tick_in rising edge, independent of en.

Behaviour:
- Reset (rst=0, asynchronous):
  - digits=16'h0000, wrap=0, load_err=0, tick_seen=0.
  - All synchroniser and edge registers are set to 0.
  - Reset may assert at any time and takes effect immediately.
- Synchroniser:
  - tick_in passes through a SYNC_STAGES-deep flip-flop chain, then one edge register.
  - edge = sync_out & ~edge_reg.
  - For SYNC_STAGES=2: tick_in high first sampled at I_CLK edge k → edge true during cycle k+1..k+2 → digits and tick_seen update at edge k+2.
- Edge after reset: if tick_in is already high at reset release, exactly one edge is detected. This is a defined behaviour.
- Priority, evaluated per I_CLK cycle: clr > load > count.
  - An edge coincident with clr or load is dropped, not deferred.
  - tick_seen still pulses in that case.
- clr: digits←0000. wrap and load_err stay 0.
- load:
  - Valid when every digit ≤ 9, sec_tens ≤ 5, and min_tens ≤ MAX_MIN_TENS. A valid load sets digits←load_val.
  - Otherwise digits are unchanged and load_err=1 for one cycle.
  - Load does not pulse wrap.
- Count: happens when en=1 and edge=1 and neither clr nor load is asserted.
  - Up:
    - sec_units 0..9. Carry into sec_tens 0..5, then into min_units 0..9, then into min_tens 0..MAX_MIN_TENS.
    - MAX_MIN_TENS9:59 → 00:00 with wrap=1 in the same cycle digits become 00:00.
  - Down:
    - Mirror borrow chain.
    - 00:00 → MAX_MIN_TENS9:59 with wrap=1.
  - up is sampled in the counting cycle. A direction change between ticks is legal and glitch-free.
- Outputs: wrap, load_err and tick_seen are registered. Each is high for exactly one I_CLK cycle per event and never high for two consecutive cycles from one tick.
- Held tick_in: tick_in held high for any duration produces one edge. A new edge requires tick_in low for ≥ SYNC_STAGES+1 I_CLK cycles.
- digits are registered outputs. No combinational path from inputs to outputs.

Test Plan:
- Reset release with tick_in=0, en=1, up=1, 12 ticks → digits=0012. tick_seen pulses 12 times. wrap never asserts.
- load_val=16'h5958, then 2 up ticks → 5959, then 0000 with wrap high one cycle on the second tick.
- Load 0000, up=0, 1 tick → digits=5959, wrap pulse. A further tick → 5958, no wrap.
- load_val=16'h0A00, then 16'h0060 → both rejected with load_err pulse. digits unchanged at the prior value.
- en=0 during 5 ticks, then en=1 for 1 tick → digits advance by 1 only. tick_seen pulses 6 times.
- clr asserted in the same cycle as edge → digits=0000, no increment. Assert rst mid-count at 0347 → digits=0000 immediately, without waiting for an I_CLK edge.

Source files
------------

// File: rtl/tick_bcd_timer_if.sv
// Control and data bundle between the tick-driven BCD timer and its driver/display side.
// The master drives the controls and load value; the slave (the timer) returns digits and event pulses.
interface tick_bcd_timer_if;
    logic        tick_in;
    logic        en;
    logic        up;
    logic        clr;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] digits;
    logic        wrap;
    logic        load_err;
    logic        tick_seen;

    modport master (
        output tick_in, en, up, clr, load, load_val,
        input  digits, wrap, load_err, tick_seen
    );

    modport slave (
        input  tick_in, en, up, clr, load, load_val,
        output digits, wrap, load_err, tick_seen
    );
endinterface

// File: rtl/tick_bcd_timer.sv
// MM:SS BCD timer advanced by rising edges of a divided clock that is resynchronised into I_CLK.
// Priority each cycle is clr, then load, then count; edges coincident with clr/load are dropped.
module tick_bcd_timer #(
    parameter int SYNC_STAGES  = 2,
    parameter int MAX_MIN_TENS = 5
) (
    input  logic            I_CLK,
    input  logic            rst,
    tick_bcd_timer_if.slave bus
);

    localparam logic [3:0] MT_MAX = 4'(MAX_MIN_TENS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   sync_out;
    logic                   tick_edge;

    logic [3:0] sec_u, sec_t, min_u, min_t;
    logic       wrap_q, load_err_q, tick_seen_q;

    logic [3:0] nxt_su, nxt_st, nxt_mu, nxt_mt;
    logic       nxt_wrap;
    logic       su_max, st_max, mu_max, mt_max;
    logic       su_min, st_min, mu_min, mt_min;
    logic       load_ok;

    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign tick_edge = sync_out & ~edge_q;

    // Registers clear to 0, so a tick_in already high at reset release yields one edge.
    always_ff @(posedge I_CLK or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.tick_in};
            edge_q <= sync_out;
        end
    end

    assign su_max = (sec_u == 4'd9);
    assign st_max = (sec_t == 4'd5);
    assign mu_max = (min_u == 4'd9);
    assign mt_max = (min_t == MT_MAX);
    assign su_min = (sec_u == 4'd0);
    assign st_min = (sec_t == 4'd0);
    assign mu_min = (min_u == 4'd0);
    assign mt_min = (min_t == 4'd0);

    assign load_ok = (bus.load_val[3:0]   <= 4'd9) &&
                     (bus.load_val[7:4]   <= 4'd5) &&
                     (bus.load_val[11:8]  <= 4'd9) &&
                     (bus.load_val[15:12] <= MT_MAX);

    always_comb begin
        nxt_su   = sec_u;
        nxt_st   = sec_t;
        nxt_mu   = min_u;
        nxt_mt   = min_t;
        nxt_wrap = 1'b0;
        if (bus.up) begin
            nxt_su = su_max ? 4'd0 : sec_u + 4'd1;
            if (su_max) begin
                nxt_st = st_max ? 4'd0 : sec_t + 4'd1;
                if (st_max) begin
                    nxt_mu = mu_max ? 4'd0 : min_u + 4'd1;
                    if (mu_max) begin
                        nxt_mt   = mt_max ? 4'd0 : min_t + 4'd1;
                        nxt_wrap = mt_max;
                    end
                end
            end
        end else begin
            // Borrow chain mirrors the carry chain; 00:00 rolls back to the top value.
            nxt_su = su_min ? 4'd9 : sec_u - 4'd1;
            if (su_min) begin
                nxt_st = st_min ? 4'd5 : sec_t - 4'd1;
                if (st_min) begin
                    nxt_mu = mu_min ? 4'd9 : min_u - 4'd1;
                    if (mu_min) begin
                        nxt_mt   = mt_min ? MT_MAX : min_t - 4'd1;
                        nxt_wrap = mt_min;
                    end
                end
            end
        end
    end

    always_ff @(posedge I_CLK or negedge rst) begin
        if (!rst) begin
            sec_u       <= 4'd0;
            sec_t       <= 4'd0;
            min_u       <= 4'd0;
            min_t       <= 4'd0;
            wrap_q      <= 1'b0;
            load_err_q  <= 1'b0;
            tick_seen_q <= 1'b0;
        end else begin
            wrap_q      <= 1'b0;
            load_err_q  <= 1'b0;
            tick_seen_q <= tick_edge;
            if (bus.clr) begin
                sec_u <= 4'd0;
                sec_t <= 4'd0;
                min_u <= 4'd0;
                min_t <= 4'd0;
            end else if (bus.load) begin
                if (load_ok) begin
                    sec_u <= bus.load_val[3:0];
                    sec_t <= bus.load_val[7:4];
                    min_u <= bus.load_val[11:8];
                    min_t <= bus.load_val[15:12];
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (bus.en && tick_edge) begin
                sec_u  <= nxt_su;
                sec_t  <= nxt_st;
                min_u  <= nxt_mu;
                min_t  <= nxt_mt;
                wrap_q <= nxt_wrap;
            end
        end
    end

    assign bus.digits    = {min_t, min_u, sec_t, sec_u};
    assign bus.wrap      = wrap_q;
    assign bus.load_err  = load_err_q;
    assign bus.tick_seen = tick_seen_q;

endmodule
